cla_nibble_serial_adder: RTL and testbench

- Multi-cycle adder that computes Sum = X + Y + Cin over a WIDTH-bit operand.
- Processes one 4-bit slice per clock with a 4-bit carry-lookahead slice: P = X^Y, G = X&Y, carries fully looked-ahead inside the slice. The carry between slices is registered.
- It is the addition-side companion to the team's 4-bit borrow-lookahead subtractor.
- Sits behind a start/busy/done handshake, so wide operands reuse one small lookahead slice.

---
 rtl/cla_nibble_serial_adder.sv | 160 ++++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder
// Multi-cycle adder: Sum = X + Y + Cin, one 4-bit carry-lookahead slice per clock.
// The carry between slices is registered, so WIDTH/4 cycles produce one result.
// Optional macro CLA_SERIAL_SUB_EN adds a 'sub' input. When sub=1 the block
// computes X - Y - Cin, with Cin acting as a borrow-in and Cout reporting borrow-out.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
`ifdef CLA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    logic             sub_in;
    logic [WIDTH-1:0] x_sh, y_sh;
    logic [3:0]       p, g, s;
    logic [4:0]       c;
    logic             last;

`ifdef CLA_SERIAL_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Select the active slice and resolve all four carries from P/G and the carry register
    always_comb begin
        x_sh = x_q >> {cnt_q, 2'b00};
        y_sh = y_q >> {cnt_q, 2'b00};
        p    = x_sh[3:0] ^ y_sh[3:0];
        g    = x_sh[3:0] & y_sh[3:0];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        last = (cnt_q == CW'(NSLICE - 1));
    end

    // Per-bit slice sum: propagate XOR incoming lookahead carry
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sum
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last slice, DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Datapath next values: latch operands, accumulate slices, publish result on the last slice
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is X + ~Y + ~Bin, so invert Y and the carry-in up front
                    x_d     = X;
                    y_d     = Y ^ {WIDTH{sub_in}};
                    carry_d = Cin ^ sub_in;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                acc_d[{cnt_q, 2'b00} +: 4] = s;
                carry_d = c[4];
                if (last) begin
                    cnt_d  = '0;
                    sum_d  = acc_d;
                    cout_d = c[4] ^ sub_q;
                    ovf_d  = c[3] ^ c[4];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Testbench for cla_nibble_serial_adder: random stimulus against an arithmetic
// reference model, plus directed operations with hand-computed results.
module tb_cla_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         Cin = 1'b0;
    logic         sub_i = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    wire          busy, done, Cout, overflow;
    wire  [W-1:0] Sum;

    always #5 clk = ~clk;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .X(X),
        .Y(Y),
        .Cin(Cin),
`ifdef CLA_SERIAL_SUB_EN
        .sub(sub_i),
`endif
        .busy(busy),
        .done(done),
        .Sum(Sum),
        .Cout(Cout),
        .overflow(overflow)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Plain-arithmetic reference for one operation
    task automatic compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic s, output logic [W-1:0] r, output logic co,
                           output logic ov);
        logic [W:0] full;
        if (s) begin
            full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
            ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        r  = full[W-1:0];
        co = full[W];
    endtask

    // Model: age counts edges since an accepted start (-1 = idle)
    int           age = -1;
    logic [W-1:0] pend_sum, m_sum;
    logic         pend_cout, pend_ovf, m_cout, m_ovf;

    always @(posedge clk) begin
        if (!rst_n) begin
            age = -1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (age < 0) begin
            if (start) begin
                compute(X, Y, Cin, sub_i, pend_sum, pend_cout, pend_ovf);
                age = 0;
            end
        end else begin
            age++;
            if (age == N) begin
                m_sum = pend_sum; m_cout = pend_cout; m_ovf = pend_ovf;
            end else if (age == N + 1) begin
                age = -1;
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, (age >= 0 && age < N));
            chk("done", done, (age == N));
            chk("sum", Sum, m_sum);
            chk("cout", Cout, m_cout);
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic s, input logic [W-1:0] es, input logic eco,
                         input logic eov);
        int dc;
        dc = 0;
        @(negedge clk);
        X = a; Y = b; Cin = ci; sub_i = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; X = W'($urandom); Y = W'($urandom); Cin = 1'($urandom);
        repeat (N + 1) begin
            @(negedge clk);
            if (done) dc++;
        end
        $display("op sub=%0d X=%h Y=%h Cin=%0d -> Sum=%h Cout=%0d ovf=%0d", s, a, b, ci, Sum, Cout, overflow);
        chk("lit_sum", Sum, es);
        chk("lit_cout", Cout, eco);
        chk("lit_ovf", overflow, eov);
        chk("lit_done_pulses", dc, 1);
    endtask

    logic [W-1:0] corner [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};

    initial begin
        int dc;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_sum", Sum, 16'h0000);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef CLA_SERIAL_SUB_EN
        do_op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        do_op(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        sub_i = 1'b0;
`endif

        // A start pulse during RUN must not disturb the running operation
        @(negedge clk); X = 16'h0010; Y = 16'h0020; Cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; X = 16'hAAAA; Y = 16'h5555;
        @(negedge clk); start = 1'b0;
        repeat (N - 1) @(negedge clk);
        $display("op ignored-start X=0010 Y=0020 -> Sum=%h", Sum);
        chk("ignore_start_sum", Sum, 16'h0030);

        // Reset at E2 aborts the operation: no done pulse, outputs cleared
        @(negedge clk); X = 16'h1111; Y = 16'h2222; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        dc = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (done) dc++;
        end
        $display("op midrun-reset -> Sum=%h done_pulses=%0d", Sum, dc);
        chk("midrun_reset_done", dc, 0);
        chk("midrun_reset_sum", Sum, 16'h0000);
        chk("midrun_reset_busy", busy, 1'b0);

        // Random traffic, including back-to-back starts, mid-op noise and resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            X = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            Y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            Cin = 1'($urandom);
`ifdef CLA_SERIAL_SUB_EN
            sub_i = 1'($urandom);
`endif
            rst_n = ($urandom_range(0, 59) != 0);
            if (done) $display("op random X/Y latched -> Sum=%h Cout=%0d ovf=%0d", Sum, Cout, overflow);
        end

        // Reset after random activity
        @(negedge clk); start = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_sum", Sum, 16'h0000);
        chk("post_reset_cout", Cout, 1'b0);
        chk("post_reset_ovf", overflow, 1'b0);
        chk("post_reset_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
